// File: rtl/inv_pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// inv_pipe_skid_stage
//
// Registered pipeline stage that sits directly downstream of the
// transmission-gate inverter array. It captures the inverter word on a
// valid/ready handshake, optionally re-inverting it. It then presents the word
// to the next stage through a two-entry skid buffer, so in_ready is a pure flop
// with no combinational path from out_ready. It also counts completed output
// transfers.
//
// Parameters
//   WIDTH    data word width in bits
//   INVERT   1: capture ~in_data, 0: capture in_data unchanged
//   COUNT_W  width of the output transfer counter
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    upstream word present on in_data
//   in_ready    stage can accept a word this cycle (registered)
//   in_data     word from the inverter array
//   out_valid   out_data holds a valid word
//   out_ready   downstream accepts out_data this cycle
//   out_data    head-of-buffer word (registered)
//   xfer_count  completed output handshakes, modulo 2^COUNT_W
// ---------------------------------------------------------------------------
module inv_pipe_skid_stage #(
    parameter int WIDTH   = 8,
    parameter int INVERT  = 1,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [COUNT_W-1:0] xfer_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic               in_ready_q, in_ready_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic               accept;
    logic               take;
    logic [WIDTH-1:0]   in_word;

    assign in_word = (INVERT != 0) ? ~in_data : in_data;

    // Handshakes use only registered signals on the stage side, so an X on
    // in_data while in_valid is low can never reach a register.
    assign accept = in_valid & in_ready_q;
    assign take   = out_valid & out_ready;

    // Next-state logic. In BUSY with simultaneous accept and take the new word
    // directly replaces the head; the skid entry is only used when the head
    // is stalled.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = BUSY;
                    main_d  = in_word;
                end
            end
            BUSY: begin
                if (accept && take) begin
                    main_d = in_word;
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = in_word;
                end else if (take) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (take) begin
                    state_d = BUSY;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // in_ready is registered from the next state, which keeps out_ready off
    // the upstream timing path.
    assign in_ready_d = (state_d != FULL);
    assign count_d    = count_q + {{(COUNT_W-1){1'b0}}, take};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            count_q    <= count_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (state_q != EMPTY);
    assign out_data   = main_q;
    assign xfer_count = count_q;

endmodule
